// File: rtl/ser_40_pkg.sv
// ser_40_pkg: shared state type and counter sizing for the 40 MHz serializer
package ser_40_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_bits(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/ser_40_hold.sv
// ser_40_hold: one-entry holding register with full flag
module ser_40_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clock_40,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  // full flag: set on load, cleared on unload or reset
  always_ff @(posedge clock_40)
    if (reset) full <= 1'b0;
    else if (load) full <= 1'b1;
    else if (unload) full <= 1'b0;
  // capture the offered word when accepted
  always_ff @(posedge clock_40)
    if (load) q <= d;
endmodule

// File: rtl/ser_40_pipe.sv
// ser_40_pipe: parallel-to-serial shifter with one-word holding buffer
module ser_40_pipe
  import ser_40_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 0,
  parameter bit IDLE_LEVEL = 0
) (
  input  logic             clock_40,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] held;
  logic             full;
  logic             last;
  logic             unload;
  function automatic logic lead(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w << 1 : w >> 1;
  endfunction
  assign in_ready = !reset && !full;
  assign last     = state == SHIFT && cnt == LAST;
  assign unload   = full && (state == IDLE || last);
  assign busy     = state == SHIFT || full;
  ser_40_hold #(.WIDTH(WIDTH)) u_hold (
    .clock_40(clock_40),
    .reset(reset),
    .load(in_valid && in_ready),
    .unload(unload),
    .d(data_in),
    .q(held),
    .full(full)
  );
  // shift engine: start a word from the holding register, step through its bits, or idle
  always_ff @(posedge clock_40)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      data_out    <= IDLE_LEVEL;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (unload) begin
      state       <= SHIFT;
      cnt         <= '0;
      sh          <= adv(held);
      data_out    <= lead(held);
      out_valid   <= 1'b1;
      frame_start <= 1'b1;
    end else if (state == SHIFT && !last) begin
      cnt         <= cnt + 1'b1;
      sh          <= adv(sh);
      data_out    <= lead(sh);
      frame_start <= 1'b0;
    end else begin
      state       <= IDLE;
      cnt         <= '0;
      data_out    <= IDLE_LEVEL;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
endmodule

// File: tb/tb_ser_40_pipe.sv
// tb_ser_40_pipe: vector table, corner sequences and randomized model check
`timescale 1ns/100ps
module tb_ser_40_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [7:0] din = '0;
  logic rdy0, d0, ov0, fs0, b0;
  logic rdy1, d1, ov1, fs1, b1;
  logic vld2 = 1'b0;
  logic [1:0] din2 = '0;
  logic rdy2, d2, ov2, fs2, b2;
  int tests = 0;
  int fails = 0;

  always #12.5 clk = ~clk;

  ser_40_pipe #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(0)) u0 (
    .clock_40(clk), .reset(rst), .data_in(din), .in_valid(vld), .in_ready(rdy0),
    .data_out(d0), .out_valid(ov0), .frame_start(fs0), .busy(b0));
  ser_40_pipe #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1)) u1 (
    .clock_40(clk), .reset(rst), .data_in(din), .in_valid(vld), .in_ready(rdy1),
    .data_out(d1), .out_valid(ov1), .frame_start(fs1), .busy(b1));
  ser_40_pipe #(.WIDTH(2), .MSB_FIRST(0), .IDLE_LEVEL(1)) u2 (
    .clock_40(clk), .reset(rst), .data_in(din2), .in_valid(vld2), .in_ready(rdy2),
    .data_out(d2), .out_valid(ov2), .frame_start(fs2), .busy(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v;
    logic [7:0] d;
    logic rdy, ov, fs, busy, dl, dm;
  } vec_t;
  vec_t tbl[10];

  logic m_held_v;
  logic [7:0] m_held_w, m_cur;
  int m_pos;
  logic m_fs;
  logic [7:0] acc[$], got0[$], got1[$];

  task automatic model_edge(input logic v, input logic [7:0] d);
    logic rdy_pre;
    rdy_pre = !m_held_v;
    m_fs = 1'b0;
    if (m_pos >= 0 && m_pos < 7) m_pos++;
    else if (m_held_v) begin
      m_cur = m_held_w;
      m_held_v = 1'b0;
      m_pos = 0;
      m_fs = 1'b1;
    end else m_pos = -1;
    if (v && rdy_pre) begin
      m_held_v = 1'b1;
      m_held_w = d;
      acc.push_back(d);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] ws[3];
    logic [7:0] a0, a1;
    int idx, n0, n1, k;
    logic r, any_ov;
    logic exp_ov2[6], exp_d2[6], exp_fs2[6];
    w = 8'hA5;
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b1, i == 1, 1'b1, w[i-1], w[8-i]};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    tick();
    tick();
    chk("reset_ready", rdy0, 0);
    chk("reset_ov", {ov0, ov1, ov2}, 0);
    chk("reset_fs_busy", {fs0, b0, fs1, b1, fs2, b2}, 0);
    chk("reset_idle_level", {d0, d1, d2}, 3'b011);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {rdy0, rdy1, rdy2}, 3'b111);

    for (int i = 0; i < 10; i++) begin
      vld = tbl[i].v;
      din = tbl[i].d;
      tick();
      chk($sformatf("a5_row%0d_ctl", i), {rdy0, ov0, fs0, b0}, {tbl[i].rdy, tbl[i].ov, tbl[i].fs, tbl[i].busy});
      chk($sformatf("a5_row%0d_lsb", i), d0, tbl[i].dl);
      chk($sformatf("a5_row%0d_msb", i), {d1, ov1, fs1}, {tbl[i].dm, tbl[i].ov, tbl[i].fs});
    end

    ws[0] = 8'hFF;
    ws[1] = 8'h00;
    ws[2] = 8'hC3;
    idx = 0;
    for (int e = 1; e <= 26; e++) begin
      vld = idx < 3;
      din = ws[idx > 2 ? 2 : idx];
      r = rdy0;
      tick();
      if (vld && r) idx++;
      k = e - 1;
      w = ws[(k < 1 ? 0 : (k > 24 ? 23 : k - 1)) / 8];
      chk($sformatf("stream_e%0d_ov", e), ov0, k >= 1 && k <= 24);
      chk($sformatf("stream_e%0d_fs", e), fs0, k == 1 || k == 9 || k == 17);
      if (k >= 1 && k <= 24) chk($sformatf("stream_e%0d_d", e), d0, w[(k-1)%8]);
      chk($sformatf("stream_e%0d_ready", e), rdy0, !(e == 1 || (e >= 3 && e <= 9) || (e >= 11 && e <= 17)));
    end
    vld = 1'b0;

    w = 8'h3C;
    vld = 1'b1;
    din = 8'h3C;
    tick();
    din = 8'h81;
    tick();
    tick();
    vld = 1'b0;
    tick();
    tick();
    tick();
    chk("midword_pre_lsb", {ov0, b0, d0}, {1'b1, 1'b1, w[4]});
    chk("midword_pre_msb", {ov1, b1, d1}, {1'b1, 1'b1, w[3]});
    chk("midword_held", rdy0, 0);
    rst = 1'b1;
    tick();
    chk("midword_reset_u0", {ov0, b0, d0, fs0, rdy0}, 5'b00000);
    chk("midword_reset_u1", {ov1, b1, d1, fs1}, 4'b0010);
    rst = 1'b0;
    any_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      any_ov |= ov0 | ov1 | b0 | b1;
    end
    chk("midword_no_leftover", any_ov, 0);
    chk("midword_ready_again", rdy0, 1);

    exp_ov2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d2  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_fs2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int e = 1; e <= 6; e++) begin
      vld2 = e <= 3;
      din2 = e == 1 ? 2'b01 : 2'b10;
      tick();
      chk($sformatf("w2_e%0d", e), {ov2, d2, fs2}, {exp_ov2[e-1], exp_d2[e-1], exp_fs2[e-1]});
    end
    vld2 = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_held_v = 1'b0;
    m_held_w = '0;
    m_cur = '0;
    m_pos = -1;
    m_fs = 1'b0;
    n0 = 0;
    n1 = 0;
    a0 = '0;
    a1 = '0;
    for (int c = 0; c < 1020; c++) begin
      vld = c < 1000 ? 1'($urandom % 2) : 1'b0;
      din = 8'($urandom);
      model_edge(vld, din);
      tick();
      chk($sformatf("rand_c%0d_u0", c), {rdy0, ov0, fs0, b0, d0},
          {!m_held_v, m_pos >= 0, m_fs, m_pos >= 0 || m_held_v, m_pos < 0 ? 1'b0 : m_cur[m_pos]});
      chk($sformatf("rand_c%0d_u1", c), {rdy1, ov1, fs1, b1, d1},
          {!m_held_v, m_pos >= 0, m_fs, m_pos >= 0 || m_held_v, m_pos < 0 ? 1'b1 : m_cur[7-m_pos]});
      if (ov0) begin
        if (fs0) n0 = 0;
        a0[n0 % 8] = d0;
        n0++;
        if (n0 == 8) got0.push_back(a0);
      end
      if (ov1) begin
        if (fs1) n1 = 0;
        a1[7 - n1 % 8] = d1;
        n1++;
        if (n1 == 8) got1.push_back(a1);
      end
    end
    chk("sb_count_u0", got0.size(), acc.size());
    chk("sb_count_u1", got1.size(), acc.size());
    for (int i = 0; i < acc.size() && i < got0.size() && i < got1.size(); i++) begin
      chk($sformatf("sb_word%0d_u0", i), got0[i], acc[i]);
      chk($sformatf("sb_word%0d_u1", i), got1[i], acc[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
